demux_deserializer: RTL and testbench

DEMUX_DESERIALIZER -- requirements
Module: demux_deserializer

---
 rtl/demux_pkg.sv | 20 ++
 rtl/demux_deser_lane.sv | 88 ++++++++
 rtl/demux_deserializer.sv | 60 ++++++
 tb/tb_demux_deserializer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the demux deserializer: default word length and
// the per-lane output FSM encoding.
package demux_pkg;

  // Default number of bits assembled into one word per channel.
  localparam int DEFAULT_WIDTH = 8;

  // Lane output state: EMPTY means no word is held, FULL means the holding
  // register carries a word the consumer has not taken yet.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_t;

  // Width of a bit counter able to count 0..width-1.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/demux_deser_lane.sv
// One deserializer lane: LSB-first shift register, bit counter, holding
// register with EMPTY/FULL output FSM and a sticky overflow flag.
//
// Handshake: valid/ready. A word moves to the consumer on a rising edge where
// valid=1 and ready=1. Once valid rises it stays high, with data stable, until
// that transfer happens. ready has no effect while valid=0.
module demux_deser_lane
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             bit_in,
  input  logic             ready,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             ovf,
  output logic             state_dbg
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  lane_state_t      state;

  logic [WIDTH-1:0] word;
  logic             complete;

  // The word as it stands once the current bit has been shifted in; on the
  // last bit of a word this is the finished word.
  assign word     = {bit_in, sr[WIDTH-1:1]};
  assign complete = en && (cnt == LAST);

  // Shift register and bit counter advance only on accepted bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (en) begin
      sr  <= word;
      cnt <= complete ? '0 : cnt + 1'b1;
    end
  end

  // Output FSM with holding register; a completed word is dropped (and
  // overflow raised) only when the held word is not being consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      data  <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (complete) begin
            data  <= word;
            state <= FULL;
          end
        end
        FULL: begin
          if (complete) begin
            if (ready) begin
              data <= word;
            end
          end else if (ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
      // Set has priority over clear so a coincident overflow is never lost.
      if (state == FULL && complete && !ready) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

  assign valid     = (state == FULL);
  assign state_dbg = state;

endmodule

// File: rtl/demux_deserializer.sv
// Two-channel deserializer behind an upstream 1:2 demux. The top only steers
// each qualified bit to the lane named by sel; all word assembly, holding and
// overflow tracking live in the lanes.
module demux_deserializer
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid,
  input  logic             sel,
  input  logic [1:0]       din,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] ch0_data,
  output logic             ch0_valid,
  input  logic             ch0_ready,
  output logic             ch0_ovf,
  output logic [WIDTH-1:0] ch1_data,
  output logic             ch1_valid,
  input  logic             ch1_ready,
  output logic             ch1_ovf,
  output logic             ch0_state,
  output logic             ch1_state
);

  logic en0;
  logic en1;

  // Only the selected lane sees an enable; din[sel] is the bit for that lane.
  assign en0 = bit_valid & ~sel;
  assign en1 = bit_valid &  sel;

  demux_deser_lane #(.WIDTH(WIDTH)) u_lane0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en0),
    .bit_in    (din[0]),
    .ready     (ch0_ready),
    .clr_ovf   (clr_ovf),
    .data      (ch0_data),
    .valid     (ch0_valid),
    .ovf       (ch0_ovf),
    .state_dbg (ch0_state)
  );

  demux_deser_lane #(.WIDTH(WIDTH)) u_lane1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en1),
    .bit_in    (din[1]),
    .ready     (ch1_ready),
    .clr_ovf   (clr_ovf),
    .data      (ch1_data),
    .valid     (ch1_valid),
    .ovf       (ch1_ovf),
    .state_dbg (ch1_state)
  );

endmodule

// File: tb/tb_demux_deserializer.sv
// Bench for demux_deserializer: directed scenarios followed by random traffic,
// all checked against a word-level reference model of the two channels.
module tb_demux_deserializer;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         bit_valid;
  logic         sel;
  logic [1:0]   din;
  logic         clr_ovf;
  logic [W-1:0] ch0_data;
  logic         ch0_valid;
  logic         ch0_ready;
  logic         ch0_ovf;
  logic [W-1:0] ch1_data;
  logic         ch1_valid;
  logic         ch1_ready;
  logic         ch1_ovf;
  logic         ch0_state;
  logic         ch1_state;

  demux_deserializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_valid (bit_valid),
    .sel       (sel),
    .din       (din),
    .clr_ovf   (clr_ovf),
    .ch0_data  (ch0_data),
    .ch0_valid (ch0_valid),
    .ch0_ready (ch0_ready),
    .ch0_ovf   (ch0_ovf),
    .ch1_data  (ch1_data),
    .ch1_valid (ch1_valid),
    .ch1_ready (ch1_ready),
    .ch1_ovf   (ch1_ovf),
    .ch0_state (ch0_state),
    .ch1_state (ch1_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters and scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  // Reference model: per channel, bits gathered so far, how many, the word
  // on offer, whether one is on offer, and the sticky drop flag.
  logic [W-1:0] m_acc  [2];
  int           m_cnt  [2];
  logic [W-1:0] m_data [2];
  bit           m_full [2];
  bit           m_ovf  [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      m_acc[l]  = '0;
      m_cnt[l]  = 0;
      m_data[l] = '0;
      m_full[l] = 0;
      m_ovf[l]  = 0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic model_update(input logic bv, input logic s, input logic [1:0] d,
                              input logic r0, input logic r1, input logic clr);
    logic [W-1:0] done_word;
    bit done;
    bit r;
    bit drop;
    for (int l = 0; l < 2; l++) begin
      done = 0;
      done_word = '0;
      drop = 0;
      r = (l == 0) ? r0 : r1;
      if (bv && (int'(s) == l)) begin
        // The n-th bit received (from 0) lands at bit position n of the word.
        m_acc[l] = m_acc[l] | (W'(d[l]) << m_cnt[l]);
        m_cnt[l] = m_cnt[l] + 1;
        if (m_cnt[l] == W) begin
          done_word = m_acc[l];
          done = 1;
          m_acc[l] = '0;
          m_cnt[l] = 0;
        end
      end
      if (done) begin
        if (!m_full[l] || r) begin
          m_data[l] = done_word;
          m_full[l] = 1;
          if (l == 0) exp_q0.push_back(done_word);
          else        exp_q1.push_back(done_word);
        end else begin
          drop = 1;
        end
      end else if (m_full[l] && r) begin
        m_full[l] = 0;
      end
      if (clr)  m_ovf[l] = 0;
      if (drop) m_ovf[l] = 1;
    end
  endtask

  task automatic compare_all();
    check("ch0_data",  ch0_data,  m_data[0]);
    check("ch0_valid", ch0_valid, m_full[0]);
    check("ch0_ovf",   ch0_ovf,   m_ovf[0]);
    check("ch0_state", ch0_state, m_full[0]);
    check("ch1_data",  ch1_data,  m_data[1]);
    check("ch1_valid", ch1_valid, m_full[1]);
    check("ch1_ovf",   ch1_ovf,   m_ovf[1]);
    check("ch1_state", ch1_state, m_full[1]);
  endtask

  // ---------------- driver tasks ----------------
  // One clock: drive at negedge, score consumptions, model the edge, check.
  task automatic step(input logic bv, input logic s, input logic [1:0] d,
                      input logic r0, input logic r1, input logic clr);
    bit_valid = bv;
    sel       = s;
    din       = d;
    ch0_ready = r0;
    ch1_ready = r1;
    clr_ovf   = clr;
    #1;
    if (ch0_valid && ch0_ready) begin
      if (exp_q0.size() == 0) check("q0_underflow", 1, 0);
      else                    check("q0_word", ch0_data, exp_q0.pop_front());
    end
    if (ch1_valid && ch1_ready) begin
      if (exp_q1.size() == 0) check("q1_underflow", 1, 0);
      else                    check("q1_word", ch1_data, exp_q1.pop_front());
    end
    @(posedge clk);
    model_update(bv, s, d, r0, r1, clr);
    @(negedge clk);
    compare_all();
  endtask

  // Send a whole word LSB-first on one lane; the unused din bit is random.
  task automatic send_word(input logic s, input logic [W-1:0] w,
                           input logic r0, input logic r1);
    logic [1:0] d;
    for (int i = 0; i < W; i++) begin
      d = 2'($urandom_range(0, 3));
      d[s] = w[i];
      step(1'b1, s, d, r0, r1, 1'b0);
    end
  endtask

  // Asynchronous reset pulse lasting one clock, checked while asserted.
  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   d;
    rst_n = 1'b0;
    bit_valid = 1'b0;
    sel = 1'b0;
    din = 2'b00;
    clr_ovf = 1'b0;
    ch0_ready = 1'b0;
    ch1_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ch0_data",  ch0_data,  0);
    check("rst_ch0_valid", ch0_valid, 0);
    check("rst_ch1_valid", ch1_valid, 0);
    check("rst_ovf",       {ch0_ovf, ch1_ovf}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Channel 0 receives 1,0,1,1,0,0,1,0 with no consumer.
    a = 8'h4D;
    for (int i = 0; i < W - 1; i++) begin
      step(1'b1, 1'b0, {1'b0, a[i]}, 1'b0, 1'b0, 1'b0);
    end
    check("d032_not_yet", ch0_valid, 0);
    step(1'b1, 1'b0, {1'b1, a[W-1]}, 1'b0, 1'b0, 1'b0);
    check("d032_valid", ch0_valid, 1);
    check("d032_data",  ch0_data,  8'h4D);
    check("d032_ch1",   ch1_valid, 0);

    // Channel 1 word with a consumer always ready: valid lasts one clock.
    send_word(1'b1, 8'hA5, 1'b0, 1'b1);
    check("d033_valid", ch1_valid, 1);
    check("d033_data",  ch1_data,  8'hA5);
    step(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    check("d033_pulse", ch1_valid, 0);
    check("d033_keep",  ch1_data,  8'hA5);
    check("d033_ovf",   ch1_ovf,   0);

    // Channel 0 still held: a second word is dropped and flagged.
    send_word(1'b0, 8'hFF, 1'b0, 1'b0);
    check("d034_data", ch0_data, 8'h4D);
    check("d034_ovf",  ch0_ovf,  1);
    step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    check("d034_clr",  ch0_ovf,  0);
    check("d034_held", ch0_valid, 1);

    // Drain channel 0, then interleave both channels bit by bit.
    step(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    check("drain_ch0", ch0_valid, 0);
    a = 8'h0F;
    b = 8'hF0;
    for (int i = 0; i < W; i++) begin
      step(1'b1, 1'b0, {~b[i], a[i]}, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, {b[i], ~a[i]}, 1'b0, 1'b0, 1'b0);
    end
    check("d035_ch0", ch0_data, 8'h0F);
    check("d035_ch1", ch1_data, 8'hF0);
    check("d035_val", {ch0_valid, ch1_valid}, 2'b11);

    // Consume on the same edge as the next completion: no drop.
    a = 8'h81;
    for (int i = 0; i < W; i++) begin
      d = 2'($urandom_range(0, 3));
      d[0] = a[i];
      step(1'b1, 1'b0, d, (i == W - 1), 1'b0, 1'b0);
    end
    check("d037_valid", ch0_valid, 1);
    check("d037_data",  ch0_data,  8'h81);
    check("d037_ovf",   ch0_ovf,   0);

    // Reset in the middle of a word discards the partial bits.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    pulse_reset();
    check("d036_zero", {ch0_data, ch1_data, ch0_valid, ch1_valid, ch0_ovf, ch1_ovf}, 0);
    send_word(1'b0, 8'h3C, 1'b0, 1'b0);
    check("d036_data", ch0_data, 8'h3C);

    // Random traffic with occasional resets.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
      end else begin
        step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
      end
    end

    // Words still on offer must match what the model has outstanding.
    check("q0_left", exp_q0.size(), m_full[0] ? 1 : 0);
    check("q1_left", exp_q1.size(), m_full[1] ? 1 : 0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
